motor_pwm_ctrl: RTL

MOTOR_PWM_CTRL -- requirements
Module: motor_pwm_ctrl

---
 rtl/motor_pkg.sv | 37 +++
 rtl/quad_decoder.sv | 44 ++++
 rtl/motor_pwm_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared types for the motor PWM controller: bridge FSM states and quadrature step decoding.
package motor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDead,
    StRunFwd,
    StRunRev,
    StBrake
  } state_e;

  typedef enum logic [1:0] {
    QuadHold,
    QuadInc,
    QuadDec,
    QuadIllegal
  } quad_step_e;

  // Phase index along the forward sequence 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] quad_phase(logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic quad_step_e quad_step(logic [1:0] prev_ab, logic [1:0] cur_ab);
    logic [1:0] diff;
    quad_step_e step;
    diff = quad_phase(cur_ab) - quad_phase(prev_ab);
    case (diff)
      2'd1:    step = QuadInc;
      2'd3:    step = QuadDec;
      2'd2:    step = QuadIllegal;
      default: step = QuadHold;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: 2-flop synchroniser, then single-cycle step pulses.
module quad_decoder
  import motor_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enc_a,
  input  logic enc_b,
  output logic inc,
  output logic dec,
  output logic illegal
);

  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] prev_q, prev_d;
  quad_step_e step;

  always_comb begin
    meta_d = {enc_a, enc_b};
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  always_comb begin
    step    = quad_step(prev_q, sync_q);
    inc     = (step == QuadInc);
    dec     = (step == QuadDec);
    illegal = (step == QuadIllegal);
  end

endmodule

// File: rtl/motor_pwm_ctrl.sv
// H-bridge PWM controller with dead-time FSM, quadrature position counter and
// periodic speed samples delivered over a valid/ready handshake.
module motor_pwm_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned ENC_W      = 16,
  parameter int unsigned DEADTIME   = 4,
  parameter int unsigned SAMPLE_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             dir,
  input  logic             brake,
  input  logic [PWM_W-1:0] duty,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             fault_clr,
  input  logic             sample_ready,
  output logic             pwm_a,
  output logic             pwm_b,
  output logic [ENC_W-1:0] enc_count,
  output logic             sample_valid,
  output logic [ENC_W-1:0] sample_data,
  output logic             fault,
  output logic             overrun
);

  localparam int unsigned DeadW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam int unsigned DivW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [PWM_W-1:0] CntLast  = {{(PWM_W-1){1'b1}}, 1'b0};
  localparam logic [DeadW-1:0] DeadLast = DeadW'(DEADTIME - 1);
  localparam logic [DivW-1:0]  DivLast  = DivW'(SAMPLE_DIV - 1);

  logic [PWM_W-1:0] cnt_q, cnt_d, duty_q, duty_d;
  logic             wrap, raw_pwm;
  state_e           state_q, state_d;
  logic [DeadW-1:0] dead_q, dead_d;
  logic             pwm_a_q, pwm_a_d, pwm_b_q, pwm_b_d;
  logic [ENC_W-1:0] enc_count_q, enc_count_d, snap_q, snap_d;
  logic [ENC_W-1:0] sample_data_q, sample_data_d;
  logic [DivW-1:0]  div_q, div_d;
  logic             sample_valid_q, sample_valid_d;
  logic             fault_q, fault_d, overrun_q, overrun_d;
  logic             enc_inc, enc_dec, enc_illegal;
  logic             due, accept, overrun_set;

  quad_decoder u_quad_decoder (
    .clk     (clk),
    .rst_n   (rst_n),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .inc     (enc_inc),
    .dec     (enc_dec),
    .illegal (enc_illegal)
  );

  // Period is 2^PWM_W-1 so an all-ones duty stays high for the whole period.
  always_comb begin
    wrap    = (cnt_q == CntLast);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    duty_d  = wrap ? duty : duty_q;
    raw_pwm = (cnt_q < duty_q);
  end

  always_comb begin
    state_d = state_q;
    dead_d  = '0;
    case (state_q)
      StIdle:   if (enable) state_d = StDead;
      StDead: begin
        dead_d = dead_q + 1'b1;
        if (dead_q == DeadLast) state_d = dir ? StRunRev : StRunFwd;
      end
      StRunFwd: if (dir) state_d = StDead;
      StRunRev: if (!dir) state_d = StDead;
      StBrake:  if (!brake) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (brake) begin
      state_d = StBrake;
    end else if (!enable && state_q != StBrake) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    pwm_a_d = 1'b0;
    pwm_b_d = 1'b0;
    case (state_q)
      StRunFwd: pwm_a_d = raw_pwm;
      StRunRev: pwm_b_d = raw_pwm;
      StBrake: begin
        pwm_a_d = 1'b1;
        pwm_b_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    enc_count_d = enc_count_q;
    if (enc_inc) begin
      enc_count_d = enc_count_q + 1'b1;
    end else if (enc_dec) begin
      enc_count_d = enc_count_q - 1'b1;
    end
    fault_d = enc_illegal | (fault_q & ~fault_clr);
  end

  // An unaccepted sample is kept; the newer delta is dropped but the window still restarts.
  always_comb begin
    due            = (div_q == DivLast);
    div_d          = due ? '0 : div_q + 1'b1;
    accept         = sample_valid_q & sample_ready;
    sample_valid_d = sample_valid_q & ~accept;
    sample_data_d  = sample_data_q;
    snap_d         = snap_q;
    overrun_set    = 1'b0;
    if (due) begin
      snap_d = enc_count_q;
      if (!sample_valid_q || accept) begin
        sample_valid_d = 1'b1;
        sample_data_d  = enc_count_q - snap_q;
      end else begin
        overrun_set = 1'b1;
      end
    end
    overrun_d = overrun_set | (overrun_q & ~fault_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      duty_q         <= '0;
      state_q        <= StIdle;
      dead_q         <= '0;
      pwm_a_q        <= 1'b0;
      pwm_b_q        <= 1'b0;
      enc_count_q    <= '0;
      snap_q         <= '0;
      div_q          <= '0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      fault_q        <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      state_q        <= state_d;
      dead_q         <= dead_d;
      pwm_a_q        <= pwm_a_d;
      pwm_b_q        <= pwm_b_d;
      enc_count_q    <= enc_count_d;
      snap_q         <= snap_d;
      div_q          <= div_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      fault_q        <= fault_d;
      overrun_q      <= overrun_d;
    end
  end

  assign pwm_a        = pwm_a_q;
  assign pwm_b        = pwm_b_q;
  assign enc_count    = enc_count_q;
  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign fault        = fault_q;
  assign overrun      = overrun_q;

endmodule
